// File: rtl/csr_file.sv
// Machine-mode CSR file: mstatus (MIE/MPIE), misa, mtvec, mscratch, mepc,
// mcause, mhartid, with trap entry and MRET handling.
// Optional 64-bit mcycle/minstret counters with read-only shadows are
// built only when the macro CSR_COUNTERS_EN is defined.
module csr_file #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] csr_addr_in_id,
  output logic [31:0] csr_data_out,
  output logic        csr_illegal_out,
  input  logic [11:0] csr_addr_in_wb,
  input  logic        wr_csr_n_in_wb,
  input  logic [31:0] csr_data_in_wb,
  input  logic        instret_in_wb,
  input  logic        trap_in,
  input  logic [31:0] trap_cause_in,
  input  logic [31:0] trap_pc_in,
  input  logic        mret_in,
  output logic [31:0] mtvec_out,
  output logic [31:0] mepc_out
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MISA     = 12'h301;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MHARTID  = 12'hF14;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH= 12'hB82;
  localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH   = 12'hC80;
  localparam logic [11:0] ADDR_INSTRET  = 12'hC02;
  localparam logic [11:0] ADDR_INSTRETH = 12'hC82;

  localparam logic [31:0] MISA_VALUE    = 32'h4000_0100;

  logic        mie_q, mpie_q;
  logic [31:0] mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [31:0] mstatus_val;

  logic wr_en;
  logic wr_mstatus, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause;

  // Writable addresses are the only ones eligible for the read bypass.
  function automatic logic is_writable(input logic [11:0] addr);
    logic w;
    w = 1'b0;
    case (addr)
      ADDR_MSTATUS, ADDR_MTVEC, ADDR_MSCRATCH, ADDR_MEPC, ADDR_MCAUSE: w = 1'b1;
`ifdef CSR_COUNTERS_EN
      ADDR_MCYCLE, ADDR_MCYCLEH, ADDR_MINSTRET, ADDR_MINSTRETH: w = 1'b1;
`endif
      default: w = 1'b0;
    endcase
    return w;
  endfunction

  assign wr_en       = ~wr_csr_n_in_wb;
  assign mstatus_val = {24'h0, mpie_q, 3'b000, mie_q, 3'b000};

  // Write decode; trap and mret own the fields they touch on their edge.
  always_comb begin
    wr_mstatus  = wr_en && (csr_addr_in_wb == ADDR_MSTATUS) && !trap_in && !mret_in;
    wr_mtvec    = wr_en && (csr_addr_in_wb == ADDR_MTVEC);
    wr_mscratch = wr_en && (csr_addr_in_wb == ADDR_MSCRATCH);
    wr_mepc     = wr_en && (csr_addr_in_wb == ADDR_MEPC) && !trap_in;
    wr_mcause   = wr_en && (csr_addr_in_wb == ADDR_MCAUSE) && !trap_in;
  end

  // mstatus interrupt-enable stack: trap pushes, mret pops, else CSR write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_q  <= 1'b0;
      mpie_q <= 1'b0;
    end else if (trap_in) begin
      mpie_q <= mie_q;
      mie_q  <= 1'b0;
    end else if (mret_in) begin
      mie_q  <= mpie_q;
      mpie_q <= 1'b1;
    end else if (wr_mstatus) begin
      mie_q  <= csr_data_in_wb[3];
      mpie_q <= csr_data_in_wb[7];
    end
  end

  // mtvec and mscratch are only ever changed by CSR writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= 32'h0;
    end else begin
      if (wr_mtvec)    mtvec_q    <= {csr_data_in_wb[31:2], 2'b00};
      if (wr_mscratch) mscratch_q <= csr_data_in_wb;
    end
  end

  // Trap capture of mepc/mcause, otherwise software writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mepc_q   <= 32'h0;
      mcause_q <= 32'h0;
    end else if (trap_in) begin
      mepc_q   <= {trap_pc_in[31:2], 2'b00};
      mcause_q <= trap_cause_in;
    end else begin
      if (wr_mepc)   mepc_q   <= {csr_data_in_wb[31:2], 2'b00};
      if (wr_mcause) mcause_q <= csr_data_in_wb;
    end
  end

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_q, minstret_q;

  // Free-running cycle and retired-instruction counters; a write to either
  // half replaces it and holds off that counter's increment for the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle_q   <= 64'h0;
      minstret_q <= 64'h0;
    end else begin
      if (wr_en && csr_addr_in_wb == ADDR_MCYCLE)
        mcycle_q <= {mcycle_q[63:32], csr_data_in_wb};
      else if (wr_en && csr_addr_in_wb == ADDR_MCYCLEH)
        mcycle_q <= {csr_data_in_wb, mcycle_q[31:0]};
      else
        mcycle_q <= mcycle_q + 64'd1;

      if (wr_en && csr_addr_in_wb == ADDR_MINSTRET)
        minstret_q <= {minstret_q[63:32], csr_data_in_wb};
      else if (wr_en && csr_addr_in_wb == ADDR_MINSTRETH)
        minstret_q <= {csr_data_in_wb, minstret_q[31:0]};
      else if (instret_in_wb)
        minstret_q <= minstret_q + 64'd1;
    end
  end
`else
  logic unused_instret;
  assign unused_instret = instret_in_wb;
`endif

  // Combinational read port with same-cycle bypass of a pending WB write.
  always_comb begin
    csr_data_out    = 32'h0;
    csr_illegal_out = 1'b0;
    case (csr_addr_in_id)
      ADDR_MSTATUS:  csr_data_out = mstatus_val;
      ADDR_MISA:     csr_data_out = MISA_VALUE;
      ADDR_MTVEC:    csr_data_out = mtvec_q;
      ADDR_MSCRATCH: csr_data_out = mscratch_q;
      ADDR_MEPC:     csr_data_out = mepc_q;
      ADDR_MCAUSE:   csr_data_out = mcause_q;
      ADDR_MHARTID:  csr_data_out = 32'h0;
`ifdef CSR_COUNTERS_EN
      ADDR_MCYCLE,   ADDR_CYCLE:    csr_data_out = mcycle_q[31:0];
      ADDR_MCYCLEH,  ADDR_CYCLEH:   csr_data_out = mcycle_q[63:32];
      ADDR_MINSTRET, ADDR_INSTRET:  csr_data_out = minstret_q[31:0];
      ADDR_MINSTRETH,ADDR_INSTRETH: csr_data_out = minstret_q[63:32];
`endif
      default:       csr_illegal_out = 1'b1;
    endcase
    if (wr_en && (csr_addr_in_wb == csr_addr_in_id) && is_writable(csr_addr_in_id))
      csr_data_out = csr_data_in_wb;
  end

  assign mtvec_out = mtvec_q;
  assign mepc_out  = mepc_q;

endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL have parameter MTVEC_RESET, default 32'h0000_0000, reset value of mtvec.
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port csr_addr_in_id  in  12  ID-stage CSR read address.
REQ-005 SHALL have port csr_data_out  out  32  read data for csr_addr_in_id.
REQ-006 SHALL have port csr_illegal_out  out  1  high when csr_addr_in_id is unimplemented.
REQ-007 SHALL have port csr_addr_in_wb  in  12  WB-stage CSR write address.
REQ-008 SHALL have port wr_csr_n_in_wb  in  1  write enable, active-low.
REQ-009 SHALL have port csr_data_in_wb  in  32  write data.
REQ-010 SHALL have port instret_in_wb  in  1  one instruction retired this cycle.
REQ-011 SHALL have ports trap_in (in, 1), trap_cause_in (in, 32), trap_pc_in (in, 32): trap entry request, cause, faulting PC.
REQ-012 SHALL have port mret_in  in  1  MRET retiring.
REQ-013 SHALL have ports mtvec_out (out, 32) and mepc_out (out, 32): current register values.

Function
REQ-014 Implemented map SHALL be: mstatus 0x300 (MIE bit3, MPIE bit7, others read 0), misa 0x301 RO 32'h4000_0100, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mhartid 0xF14 RO 0, plus counters per REQ-024.
REQ-015 Read SHALL be combinational; unimplemented address -> csr_data_out 0, csr_illegal_out 1.
REQ-016 Read bypass: if wr_csr_n_in_wb=0, csr_addr_in_wb==csr_addr_in_id and the address is writable, csr_data_out SHALL equal csr_data_in_wb in the same cycle.
REQ-017 Writes SHALL take effect at the rising edge when wr_csr_n_in_wb=0; writes to RO or unimplemented addresses SHALL be ignored.
REQ-018 mepc writes SHALL clear bits[1:0]; mtvec writes SHALL clear bits[1:0] (direct mode only).
REQ-019 trap_in=1 at an edge: mepc<=trap_pc_in with [1:0]=0, mcause<=trap_cause_in, MPIE<=MIE, MIE<=0.
REQ-020 mret_in=1 at an edge (trap_in=0): MIE<=MPIE, MPIE<=1.
REQ-021 Priority per edge SHALL be trap_in > mret_in > CSR write for any field they share; non-shared fields written by the CSR write in the same cycle SHALL still update.
REQ-022 mtvec_out and mepc_out SHALL reflect register state (no bypass); a value updated at edge N is visible after edge N.

Reset
REQ-023 On rst_n=0, immediately and regardless of clk: mstatus=0, mtvec=MTVEC_RESET, mscratch=0, mepc=0, mcause=0, mcycle=0, minstret=0; reset deasserting mid-stream SHALL resume normal operation at the next edge with no spurious increment.

Configuration
REQ-024 With macro CSR_COUNTERS_EN defined: 64-bit mcycle (0xB00 low, 0xB80 high) and minstret (0xB02/0xB82) SHALL exist, writable; RO shadows cycle 0xC00/0xC80, instret 0xC02/0xC82.
REQ-025 mcycle SHALL increment by 1 every edge out of reset; minstret SHALL increment when instret_in_wb=1; both wrap 2^64-1 -> 0 with carry from low to high half.
REQ-026 A CSR write to a counter half SHALL replace that half and suppress that counter's increment for that edge.
REQ-027 Without CSR_COUNTERS_EN: counter registers SHALL not exist, addresses 0xB00/0xB80/0xB02/0xB82/0xC00/0xC80/0xC02/0xC82 SHALL be unimplemented per REQ-015, instret_in_wb SHALL be ignored.

Verification
REQ-028 Reset then read 0x305, 0x301, 0xF14 -> MTVEC_RESET, 32'h4000_0100, 0; read 0x7C0 -> data 0, illegal 1.
REQ-029 Write 0x341 with 32'h0000_1237 -> next-cycle read and mepc_out = 32'h0000_1234; same-cycle read of 0x341 returns 32'h0000_1237 via bypass.
REQ-030 MIE=1 via write 32'h8; trap_in with cause 32'hB, pc 32'h100 -> mepc 0x100, mcause 0xB, mstatus 32'h80; then mret_in -> mstatus 32'h88.
REQ-031 trap_in and mret_in and write of 0x300=32'h8 in one cycle -> mstatus 32'h0 (trap wins MIE), MPIE reflects prior MIE.
REQ-032 (CSR_COUNTERS_EN) write 0xB00=32'hFFFF_FFFF, 0xB80=0 -> two cycles later mcycleh=1, mcycle=0; 5 cycles with instret_in_wb=1 -> minstret +5.
REQ-033 (no CSR_COUNTERS_EN) read 0xC00 -> data 0, illegal 1; write 0xB00 -> no effect.
